// File: rtl/cnn_pkg.sv
// Shared definitions for the layer-1 CNN pipeline: sample width, layer geometry and pooling state.
package cnn_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned L1_KERNEL  = 9;
  localparam int unsigned L1_IN_W    = 96;
  localparam int unsigned L1_CONV_W  = L1_IN_W - L1_KERNEL + 1;
  localparam int unsigned L1_POOL_W  = L1_CONV_W / 2;
  localparam int unsigned L1_NUM_OUT = L1_POOL_W * L1_POOL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_t;

endpackage

// File: rtl/m_pool_relu_1_if.sv
// Feature-map stream between the conv stage, the pool/ReLU stage and the next line buffer.
interface m_pool_relu_1_if #(
  parameter int unsigned DATA_W = cnn_pkg::DATA_W
);

  logic                     start;
  logic signed [DATA_W-1:0] map_in;
  logic                     valid_in;
  logic signed [DATA_W-1:0] map_out;
  logic                     save;
  logic                     ready;

  modport master (
    output start, map_in, valid_in,
    input  map_out, save, ready
  );

  modport slave (
    input  start, map_in, valid_in,
    output map_out, save, ready
  );

endinterface

// File: rtl/m_line_buf.sv
// Half-row buffer of horizontal pair maxima; one address shared by write and async read.
module m_line_buf #(
  parameter int unsigned DEPTH  = 44,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/m_pool_relu_1.sv
// 2x2 stride-2 max pooling plus optional ReLU over the gapped layer-1 conv output stream.
module m_pool_relu_1
  import cnn_pkg::*;
#(
  parameter int unsigned MAP_W   = L1_CONV_W,
  parameter int unsigned MAP_H   = L1_CONV_W,
  parameter int unsigned DATA_W  = cnn_pkg::DATA_W,
  parameter bit          RELU_EN = 1'b1,
  parameter int unsigned NUM_OUT = L1_NUM_OUT
) (
  input logic            clk_in,
  input logic            rst_n,
  m_pool_relu_1_if.slave bus
);

  localparam int unsigned COL_W  = $clog2(MAP_W);
  localparam int unsigned ROW_W  = $clog2(MAP_H);
  localparam int unsigned LB_D   = MAP_W / 2;
  localparam int unsigned ADDR_W = $clog2(LB_D);
  localparam int unsigned CNT_W  = $clog2(NUM_OUT + 1);

  pool_state_t state, state_nxt;

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic [CNT_W-1:0]         out_cnt;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] lb_rdata;
  logic signed [DATA_W-1:0] pmax;
  logic signed [DATA_W-1:0] res;
  logic signed [DATA_W-1:0] res_relu;
  logic                     proc;
  logic                     take;
  logic                     fire;
  logic                     last;
  logic                     lb_we;
  logic [ADDR_W-1:0]        lb_addr;

  m_line_buf #(
    .DEPTH (LB_D),
    .WIDTH (DATA_W),
    .ADDR_W(ADDR_W)
  ) u_line_buf (
    .clk_in (clk_in),
    .we     (lb_we),
    .addr   (lb_addr),
    .wdata  (pmax),
    .rdata_c(lb_rdata)
  );

  // IDLE->RUN is taken combinationally from start, so a sample on the rising cycle is used
  always_comb begin
    state_nxt = state;
    proc      = bus.start && (state != DONE);
    take      = proc && bus.valid_in;
    lb_addr   = ADDR_W'(col >> 1);
    pmax      = (bus.map_in > hold) ? bus.map_in : hold;
    res       = (lb_rdata > pmax) ? lb_rdata : pmax;
    res_relu  = (RELU_EN && res[DATA_W-1]) ? '0 : res;
    lb_we     = take && col[0] && !row[0];
    fire      = take && col[0] && row[0];
    last      = fire && (out_cnt == CNT_W'(NUM_OUT - 1));

    if (!bus.start) begin
      state_nxt = IDLE;
    end else if (last) begin
      state_nxt = DONE;
    end else if (state == IDLE) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Dropping start aborts the map: counters, hold and the output register restart from zero
  always_ff @(posedge clk_in) begin
    if (!rst_n || !bus.start) begin
      col         <= '0;
      row         <= '0;
      out_cnt     <= '0;
      hold        <= '0;
      bus.map_out <= '0;
      bus.save    <= 1'b0;
    end else begin
      bus.save <= fire;
      if (take) begin
        if (!col[0]) hold <= bus.map_in;
        if (col == COL_W'(MAP_W - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(MAP_H - 1)) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (fire) begin
        bus.map_out <= res_relu;
        if (out_cnt != CNT_W'(NUM_OUT)) out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

  // ready trails DONE by one cycle so it falls the cycle after the final save
  always_ff @(posedge clk_in) begin
    if (!rst_n) bus.ready <= 1'b1;
    else        bus.ready <= (state != DONE);
  end

endmodule

// File: tb/tb_m_pool_relu_1.sv
// Scoreboard bench for m_pool_relu_1: ReLU and bypass instances fed the same stream.
module tb_m_pool_relu_1;

  localparam int W  = 88;
  localparam int H  = 88;
  localparam int NO = 1936;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  m_pool_relu_1_if #(.DATA_W(16)) bus0 ();
  m_pool_relu_1_if #(.DATA_W(16)) bus1 ();

  m_pool_relu_1 #(.RELU_EN(1'b1)) dut0 (.clk_in(clk_in), .rst_n(rst_n), .bus(bus0.slave));
  m_pool_relu_1 #(.RELU_EN(1'b0)) dut1 (.clk_in(clk_in), .rst_n(rst_n), .bus(bus1.slave));

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   cnt0 = 0, cnt1 = 0, base0 = 0, base1 = 0;
  logic [15:0] out0 [2048];
  logic [15:0] out1 [2048];

  // bench-side reference: full image plus its own stream position
  logic signed [15:0] img [H][W];
  int  mcol = 0, mrow = 0, mcnt = 0;
  bit  mdone = 0;
  bit  st = 0;
  bit  rst_lvl = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (bus0.save === 1'b1) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL save0_unexpected cyc=%0d value=%0d", cyc, bus0.map_out);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (bus0.map_out !== e.val || e.due != cyc) begin
          n_fail++;
          $display("FAIL out0 got %h at cyc %0d, expected %h at cyc %0d", bus0.map_out, cyc, e.val, e.due);
        end
      end
      if (cnt0 - base0 >= 0 && cnt0 - base0 < 2048) out0[cnt0-base0] = bus0.map_out;
      cnt0++;
    end else if (q0.size() != 0 && q0[0].due <= cyc) begin
      n_cmp++; n_fail++;
      $display("FAIL save0_missing cyc=%0d expected %h", cyc, q0[0].val);
      void'(q0.pop_front());
    end
    if (bus1.save === 1'b1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL save1_unexpected cyc=%0d value=%0d", cyc, bus1.map_out);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (bus1.map_out !== e.val || e.due != cyc) begin
          n_fail++;
          $display("FAIL out1 got %h at cyc %0d, expected %h at cyc %0d", bus1.map_out, cyc, e.val, e.due);
        end
      end
      if (cnt1 - base1 >= 0 && cnt1 - base1 < 2048) out1[cnt1-base1] = bus1.map_out;
      cnt1++;
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      n_cmp++; n_fail++;
      $display("FAIL save1_missing cyc=%0d expected %h", cyc, q1[0].val);
      void'(q1.pop_front());
    end
  end

  function automatic logic signed [15:0] smax(input logic signed [15:0] a, input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [15:0] pix(input int kind, input int r, input int c);
    if (kind == 0) return 16'(r * W + c);
    if (kind == 1) return 16'hFFFB;
    if ((r == 1 && c == 1) || (r == 2 && c == 3) || (r == 87 && c == 86)) return 16'd300;
    return 16'd0;
  endfunction

  // Drive one cycle on the falling edge and update the reference/scoreboard
  task automatic feed(input logic [15:0] v, input bit vld);
    logic signed [15:0] m;
    exp_t e;
    @(negedge clk_in);
    rst_n = rst_lvl;
    bus0.start = st;     bus1.start = st;
    bus0.map_in = v;     bus1.map_in = v;
    bus0.valid_in = vld; bus1.valid_in = vld;
    if (!rst_lvl || !st) begin
      mcol = 0; mrow = 0; mcnt = 0; mdone = 0;
    end else if (vld && !mdone) begin
      img[mrow][mcol] = v;
      if (mrow[0] && mcol[0]) begin
        m = smax(smax(img[mrow-1][mcol-1], img[mrow-1][mcol]), smax(img[mrow][mcol-1], img[mrow][mcol]));
        e.due = cyc + 1;
        e.val = m;
        q1.push_back(e);
        e.val = (m < 0) ? 16'd0 : m;
        q0.push_back(e);
        mcnt++;
        if (mcnt == NO) mdone = 1;
      end
      if (mcol == W - 1) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
  endtask

  task automatic begin_map();
    st = 0;
    feed(16'd0, 1'b0);
    feed(16'd0, 1'b0);
    base0 = cnt0;
    base1 = cnt1;
    st = 1;
  endtask

  task automatic run_map(input int kind, input bit gapped, input int limit);
    int fed = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (limit > 0 && fed == limit) return;
        feed(pix(kind, r, c), 1'b1);
        fed++;
      end
      if (gapped) for (int g = 0; g < 8; g++) feed(16'h7777, 1'b0);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4; i++) feed(16'd0, 1'b0);
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain pending %0d/%0d, expected 0/0", name, q0.size(), q1.size());
    end
  endtask

  task automatic check_count(input string name, input int want);
    n_cmp++;
    if (cnt0 - base0 != want || cnt1 - base1 != want) begin
      n_fail++;
      $display("FAIL %s_count got %0d/%0d, expected %0d", name, cnt0 - base0, cnt1 - base1, want);
    end
  endtask

  task automatic test_reset();
    rst_lvl = 0; st = 0;
    for (int i = 0; i < 3; i++) feed(16'd0, 1'b0);
    n_cmp++;
    if (bus0.map_out !== 16'd0 || bus0.save !== 1'b0 || bus0.ready !== 1'b1 ||
        bus1.map_out !== 16'd0 || bus1.save !== 1'b0 || bus1.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values got out=%h save=%b ready=%b, expected 0000 0 1", bus0.map_out, bus0.save, bus0.ready);
    end
    rst_lvl = 1;
    feed(16'd0, 1'b0);
  endtask

  task automatic test_ramp_and_overrun();
    int bad = 0;
    begin_map();
    run_map(0, 1'b0, 0);
    feed(16'd0, 1'b0);
    n_cmp++;
    if (bus0.save !== 1'b1 || bus0.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_last_save got save=%b ready=%b, expected 1 1", bus0.save, bus0.ready);
    end
    feed(16'd0, 1'b0);
    n_cmp++;
    if (bus0.ready !== 1'b0 || bus1.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_ready_fall got %b/%b, expected 0", bus0.ready, bus1.ready);
    end
    check_count("ramp", NO);
    for (int k = 0; k < NO; k++)
      if (out0[k] !== 16'((2 * (k / 44) + 1) * W + 2 * (k % 44) + 1)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ramp_closed_form got %0d wrong outputs, expected 0", bad);
    end
    for (int i = 0; i < 20; i++) feed(16'(i + 5000), 1'b1);
    drain("overrun");
    n_cmp++;
    if (bus0.ready !== 1'b0 || dut0.out_cnt !== 11'd1936) begin
      n_fail++;
      $display("FAIL overrun_hold got ready=%b out_cnt=%0d, expected 0 1936", bus0.ready, dut0.out_cnt);
    end
    check_count("overrun", NO);
    st = 0;
    for (int i = 0; i < 3; i++) feed(16'd0, 1'b0);
    n_cmp++;
    if (bus0.ready !== 1'b1 || bus0.map_out !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_return got ready=%b out=%h, expected 1 0000", bus0.ready, bus0.map_out);
    end
  endtask

  task automatic test_negative();
    int bad = 0;
    begin_map();
    run_map(1, 1'b0, 0);
    drain("neg");
    check_count("neg", NO);
    for (int k = 0; k < NO; k++)
      if (out0[k] !== 16'd0 || out1[k] !== 16'hFFFB) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL neg_values got %0d wrong outputs, expected 0", bad);
    end
  endtask

  task automatic test_gapped();
    int bad = 0;
    begin_map();
    run_map(0, 1'b1, 0);
    drain("gap");
    check_count("gap", NO);
    for (int k = 0; k < NO; k++)
      if (out0[k] !== 16'((2 * (k / 44) + 1) * W + 2 * (k % 44) + 1)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL gap_closed_form got %0d wrong outputs, expected 0", bad);
    end
  endtask

  task automatic test_single_max();
    int nz = 0;
    begin_map();
    run_map(2, 1'b0, 0);
    drain("peak");
    check_count("peak", NO);
    for (int k = 0; k < NO; k++) if (out0[k] !== 16'd0) nz++;
    n_cmp++;
    if (out0[0] !== 16'd300 || out0[45] !== 16'd300 || out0[1935] !== 16'd300 || nz != 3) begin
      n_fail++;
      $display("FAIL peak_positions got %0d/%0d/%0d nonzero=%0d, expected 300/300/300 nonzero=3",
               out0[0], out0[45], out0[1935], nz);
    end
  endtask

  task automatic test_abort(input bit by_reset);
    begin_map();
    run_map(0, 1'b0, 1000);
    if (by_reset) begin
      rst_lvl = 0;
      feed(16'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        feed(16'd0, 1'b1);
        n_cmp++;
        if (bus0.save !== 1'b0 || bus0.ready !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_midmap got save=%b ready=%b, expected 0 1", bus0.save, bus0.ready);
        end
      end
      rst_lvl = 1;
    end
    drain(by_reset ? "rst_abort" : "abort");
    begin_map();
    run_map(0, 1'b0, 0);
    drain(by_reset ? "rst_rerun" : "rerun");
    check_count(by_reset ? "rst_rerun" : "rerun", NO);
    n_cmp++;
    if (out0[0] !== 16'd89) begin
      n_fail++;
      $display("FAIL abort_first got %0d, expected 89", out0[0]);
    end
  endtask

  initial begin
    bus0.start = 1'b0; bus1.start = 1'b0;
    bus0.map_in = '0;  bus1.map_in = '0;
    bus0.valid_in = 1'b0; bus1.valid_in = 1'b0;
    test_reset();
    test_ramp_and_overrun();
    test_negative();
    test_gapped();
    test_single_max();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
